sc_stream_acc: RTL
==================

// Module: sc_stream_acc
// PURPOSE
//  Stochastic-to-binary converter sitting directly downstream of the 16-input APC adder.
//  - Counts the 1s in the adder's scaled output bitstream over a window of 2**LOG_WIN valid cycles.
//  - Presents the count as a binary result through a valid/ready handshake.
//  - The result is the window estimate of sum(in)/16, in units of 2**-LOG_WIN.
// PARAMETERS
//  LOG_WIN  8  window length exponent; window = 2**LOG_WIN accepted bits (1..16)
// PORTS
//  clk        in   1          clock, all state updates on rising edge
//  rst        in   1          synchronous, active-high reset
//  start      in   1          pulse: begin a new accumulation window
//  abort      in   1          drop the current window, return to IDLE, no result
//  in_bit     in   1          stochastic bit from APC adder output
//  in_valid   in   1          in_bit qualifies this cycle; low = stall (bit ignored)
//  busy       out  1          high in ACC state
//  out_cnt    out  LOG_WIN+1  number of 1s seen in window (0..2**LOG_WIN)
//  out_valid  out  1          out_cnt holds a completed result
//  out_ready  in   1          consumer accepts result when out_valid & out_ready
// BEHAVIOUR
//  Reset (rst=1 at edge, overrides all other inputs):
//  - state=IDLE; busy=0, out_valid=0, out_cnt=0, internal window counter=0.
//  FSM states: IDLE, ACC, DONE.
//  IDLE:
//  - start=1 -> ACC next cycle; ones counter and window counter cleared.
//  - abort in IDLE has no effect.
//  ACC:
//  - each cycle with in_valid=1: win_cnt += 1; ones += in_bit.
//  - the accepted bit that makes win_cnt reach 2**LOG_WIN is included in the count.
//  - next cycle: DONE, out_valid=1, out_cnt=final count. Latency = 1 cycle after the last bit.
//  - in_valid=0: counters hold, no timeout.
//  - start while in ACC is ignored; the window is not restarted.
//  - abort=1 -> IDLE next cycle; counters cleared, out_valid stays 0. Abort beats window completion in the same cycle.
//  DONE:
//  - out_valid=1, out_cnt stable until the handshake.
//  - in_bit and in_valid are ignored.
//  - out_valid & out_ready -> IDLE next cycle; out_valid=0. out_cnt keeps its last value, not cleared.
//  - handshake and start in the same cycle -> ACC directly; result consumed, new window begins, no lost cycle.
//  - start without out_ready is ignored.
//  - abort in DONE drops the result -> IDLE.
//  Widths:
//  - ones counter is LOG_WIN+1 bits, so an all-ones window reports exactly 2**LOG_WIN and never wraps.
//  - window counter is LOG_WIN+1 bits and is compared against 2**LOG_WIN.
//  - rst mid-window discards partial counts.
// TESTING
//  1 LOG_WIN=4; start, then 16 valid cycles with in_bit=1
//    -> out_valid rises 1 cycle after the 16th bit; out_cnt=16.
//  2 LOG_WIN=4; 16 valid bits alternating 1,0 with in_valid deasserted every 3rd cycle
//    -> out_cnt=8; busy high throughout the stalled window.
//  3 out_ready held low 5 cycles after DONE -> out_valid and out_cnt stable;
//    then out_ready=1 with start=1 -> next window begins, busy=1 next cycle.
//  4 abort on the cycle of the 16th valid bit -> IDLE, out_valid never asserted; a following start gives a fresh count.
//  5 rst asserted after 7 of 16 bits -> all outputs 0 next cycle; new window counts only post-reset bits.
//  6 LOG_WIN=8; drive in_bit from apcadd16 with 8 of 16 inputs at p=1 and the rest at p=0
//    -> out_cnt within 128±16.

Source files
------------

// File: rtl/sc_stream_acc_if.sv
// Stream interface between a bitstream producer/result consumer and the
// stochastic-to-binary accumulator.
//
// Handshake: out_cnt is a completed result whenever out_valid is high, and it
// holds steady until the consumer takes it. A transfer happens on a rising
// clock edge where out_valid and out_ready are both high. out_valid never
// waits on out_ready. in_bit is consumed on every edge where in_valid is high
// while a window is open; in_valid low is a stall, and there is no
// back-pressure on the input side.
interface sc_stream_acc_if #(
  parameter int LOG_WIN = 8
);
  logic               start;
  logic               abort;
  logic               in_bit;
  logic               in_valid;
  logic               busy;
  logic [LOG_WIN:0]   out_cnt;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output start, abort, in_bit, in_valid, out_ready,
    input  busy, out_cnt, out_valid
  );

  modport slave (
    input  start, abort, in_bit, in_valid, out_ready,
    output busy, out_cnt, out_valid
  );
endinterface

// File: rtl/sc_stream_acc.sv
// Stochastic-to-binary converter. It counts the 1s in a bitstream over a
// window of 2**LOG_WIN accepted bits and offers the count as a result.
// fsm_state exposes the controller state: 0 = IDLE, 1 = ACC, 2 = DONE.
module sc_stream_acc #(
  parameter int LOG_WIN = 8
) (
  input  logic              clk,
  input  logic              rst,
  sc_stream_acc_if.slave    bus,
  output logic [1:0]        fsm_state
);
  localparam int CW = LOG_WIN + 1;
  // The window length is 2**LOG_WIN. The counters are one bit wider, so an
  // all-ones window reads exactly 2**LOG_WIN and never wraps.
  localparam logic [CW-1:0] WIN = {1'b1, {LOG_WIN{1'b0}}};
  localparam logic [CW-1:0] ONE = {{LOG_WIN{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   ones, ones_nxt;
  logic [CW-1:0]   win_cnt, win_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   ones_inc;
  logic [CW-1:0]   win_inc;

  assign ones_inc = ones + {{LOG_WIN{1'b0}}, bus.in_bit};
  assign win_inc  = win_cnt + ONE;

  // Next-state, counter and result logic for the IDLE / ACC / DONE controller.
  always_comb begin
    state_nxt = state;
    ones_nxt  = ones;
    win_nxt   = win_cnt;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = ACC;
          ones_nxt  = '0;
          win_nxt   = '0;
        end
      end
      ACC: begin
        // Abort wins over a window that would complete on the same edge.
        if (bus.abort) begin
          state_nxt = IDLE;
          ones_nxt  = '0;
          win_nxt   = '0;
        end else if (bus.in_valid) begin
          ones_nxt = ones_inc;
          win_nxt  = win_inc;
          // The bit that fills the window still counts toward the result.
          if (win_inc == WIN) begin
            state_nxt = DONE;
            cnt_nxt   = ones_inc;
          end
        end
      end
      DONE: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          ones_nxt  = '0;
          win_nxt   = '0;
        end else if (bus.out_ready) begin
          // A handshake together with start opens the next window at once.
          // cnt is left alone, so the last result stays visible.
          state_nxt = bus.start ? ACC : IDLE;
          ones_nxt  = '0;
          win_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        ones_nxt  = '0;
        win_nxt   = '0;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ones    <= '0;
      win_cnt <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      ones    <= ones_nxt;
      win_cnt <= win_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign bus.busy      = (state == ACC);
  assign bus.out_valid = (state == DONE);
  assign bus.out_cnt   = cnt;
  assign fsm_state     = state;
endmodule
